// File: rtl/air_pkg.sv
// Shared encodings for the thermostat: operating mode written by the setpoint
// editor and the actuator control state.
package air_pkg;

  typedef enum logic [1:0] {
    AIR_MANUAL = 2'b00,
    AIR_AUTO   = 2'b01,
    STOPPED    = 2'b10,
    SET_TEM    = 2'b11
  } air_state_e;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    COOL = 2'b01,
    HEAT = 2'b10,
    REST = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter advanced by a 1 Hz enable; a load beats a same-cycle tick.
module tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/air_actuator.sv
// Thermostat actuator: hysteresis control with minimum run and rest times,
// driving cooler, heater and fan enables from the setpoint and mode.
module air_actuator
  import air_pkg::*;
#(
  parameter int HYST          = 2,
  parameter int MIN_ON_TICKS  = 5,
  parameter int MIN_OFF_TICKS = 3,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] tem_reg,
  input  logic [7:0] set_tem,
  input  logic [1:0] air_state,
  output logic       cool_on,
  output logic       heat_on,
  output logic       fan_on,
  output logic [1:0] ctrl_state
);

  ctrl_state_e      state_d, state_q;
  logic             cool_d, cool_q;
  logic             heat_d, heat_q;
  logic             fan_d, fan_q;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             cnt_zero;

  air_state_e air_mode;
  assign air_mode = air_state_e'(air_state);

  // 9-bit arithmetic so set_tem + HYST near 255 cannot wrap.
  logic [8:0] tem9, set9, hyst9;
  logic       need_cool, need_heat, cool_done, heat_done;

  assign tem9      = {1'b0, tem_reg};
  assign set9      = {1'b0, set_tem};
  assign hyst9     = 9'(HYST);
  assign need_cool = tem9 > (set9 + hyst9);
  assign need_heat = (tem9 + hyst9) < set9;
  assign cool_done = tem9 <= set9;
  assign heat_done = tem9 >= set9;

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (load_val),
    .tick  (tick),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    cool_d   = cool_q;
    heat_d   = heat_q;
    fan_d    = fan_q;
    if (air_mode != SET_TEM) begin
      unique case (state_q)
        OFF: begin
          if (air_mode == AIR_AUTO && need_cool) begin
            state_d  = COOL;
            load     = 1'b1;
            load_val = CNT_W'(MIN_ON_TICKS);
          end else if (air_mode == AIR_AUTO && need_heat) begin
            state_d  = HEAT;
            load     = 1'b1;
            load_val = CNT_W'(MIN_ON_TICKS);
          end
        end
        COOL: begin
          if (air_mode == STOPPED ||
              (cnt_zero && (cool_done || air_mode == AIR_MANUAL))) begin
            state_d  = REST;
            load     = 1'b1;
            load_val = CNT_W'(MIN_OFF_TICKS);
          end
        end
        HEAT: begin
          if (air_mode == STOPPED ||
              (cnt_zero && (heat_done || air_mode == AIR_MANUAL))) begin
            state_d  = REST;
            load     = 1'b1;
            load_val = CNT_W'(MIN_OFF_TICKS);
          end
        end
        REST: begin
          if (cnt_zero) state_d = OFF;
        end
        default: state_d = OFF;
      endcase
      // Outputs decode the next state so they line up with ctrl_state.
      cool_d = (state_d == COOL);
      heat_d = (state_d == HEAT);
      fan_d  = ((state_d == COOL) || (state_d == HEAT) || (air_mode == AIR_MANUAL))
               && (air_mode != STOPPED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      cool_q  <= 1'b0;
      heat_q  <= 1'b0;
      fan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      heat_q  <= heat_d;
      fan_q   <= fan_d;
    end
  end

  assign cool_on    = cool_q;
  assign heat_on    = heat_q;
  assign fan_on     = fan_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_air_actuator.sv
// Directed self-checking bench for air_actuator with default parameters
// (HYST=2, MIN_ON_TICKS=5, MIN_OFF_TICKS=3).
module tb_air_actuator;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] tem_reg;
  logic [7:0] set_tem;
  logic [1:0] air_state;
  logic       cool_on, heat_on, fan_on;
  logic [1:0] ctrl_state;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] M_MANUAL = 2'b00, M_AUTO = 2'b01, M_STOP = 2'b10, M_SET = 2'b11;
  localparam logic [1:0] S_OFF = 2'b00, S_COOL = 2'b01, S_HEAT = 2'b10, S_REST = 2'b11;

  air_actuator dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .tem_reg    (tem_reg),
    .set_tem    (set_tem),
    .air_state  (air_state),
    .cool_on    (cool_on),
    .heat_on    (heat_on),
    .fan_on     (fan_on),
    .ctrl_state (ctrl_state)
  );

  always #5 clk = ~clk;

  // One clock edge with the given tick level; outputs are sampled 1 ns after the edge.
  task automatic cycle(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [1:0] st,
                       input logic c, input logic h, input logic f);
    logic [4:0] observed, expected;
    observed = {ctrl_state, cool_on, heat_on, fan_on};
    expected = {st, c, h, f};
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed state/cool/heat/fan=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; tem_reg = 8'd24; set_tem = 8'd24; air_state = M_AUTO;
    @(negedge clk);
    cycle(1'b0);
    check("reset_state", S_OFF, 0, 0, 0);
    reset = 1'b0;

    // Cooling run with minimum on-time
    tem_reg = 8'd27;
    cycle(1'b0);
    check("cool_start", S_COOL, 1, 0, 1);
    cycle(1'b1); cycle(1'b1);
    tem_reg = 8'd24;
    cycle(1'b1); cycle(1'b1);
    check("cool_min_on_4", S_COOL, 1, 0, 1);
    cycle(1'b1);
    check("cool_min_on_5", S_COOL, 1, 0, 1);
    cycle(1'b0);
    check("cool_to_rest", S_REST, 0, 0, 0);
    cycle(1'b1); cycle(1'b1);
    check("rest_hold_2", S_REST, 0, 0, 0);
    cycle(1'b1);
    check("rest_hold_3", S_REST, 0, 0, 0);
    cycle(1'b0);
    check("rest_to_off", S_OFF, 0, 0, 0);

    // Deadband: 22..26 around setpoint 24 stays OFF
    for (int t = 22; t <= 26; t++) begin
      tem_reg = 8'(t);
      cycle(1'b0);
      check($sformatf("deadband_%0d", t), S_OFF, 0, 0, 0);
    end

    // Manual mode in OFF runs the fan only
    air_state = M_MANUAL;
    cycle(1'b0);
    check("manual_fan", S_OFF, 0, 0, 1);
    air_state = M_AUTO;
    cycle(1'b0);
    check("auto_fan_off", S_OFF, 0, 0, 0);

    // Heating with forced stop
    tem_reg = 8'd20;
    cycle(1'b0);
    check("heat_start", S_HEAT, 0, 1, 1);
    cycle(1'b1);
    air_state = M_STOP;
    cycle(1'b0);
    check("stop_to_rest", S_REST, 0, 0, 0);
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    check("stop_rest_full", S_REST, 0, 0, 0);
    cycle(1'b0);
    check("stop_rest_off", S_OFF, 0, 0, 0);
    cycle(1'b0);
    check("stop_no_restart", S_OFF, 0, 0, 0);

    // No direct reversal COOL -> HEAT
    air_state = M_AUTO; tem_reg = 8'd27; set_tem = 8'd24;
    cycle(1'b0);
    check("rev_cool_start", S_COOL, 1, 0, 1);
    set_tem = 8'd30;
    cycle(1'b0);
    check("rev_cool_hold", S_COOL, 1, 0, 1);
    repeat (5) cycle(1'b1);
    check("rev_cool_min_on", S_COOL, 1, 0, 1);
    cycle(1'b0);
    check("rev_rest", S_REST, 0, 0, 0);
    repeat (3) cycle(1'b1);
    check("rev_rest_full", S_REST, 0, 0, 0);
    cycle(1'b0);
    check("rev_off", S_OFF, 0, 0, 0);
    cycle(1'b0);
    check("rev_heat", S_HEAT, 0, 1, 1);

    // Reset mid-run, then immediate restart without REST
    reset = 1'b1;
    cycle(1'b0);
    check("reset_mid_run", S_OFF, 0, 0, 0);
    reset = 1'b0;
    cycle(1'b0);
    check("reset_restart_heat", S_HEAT, 0, 1, 1);
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;

    // SET_TEM freezes transitions
    tem_reg = 8'd24; set_tem = 8'd24;
    cycle(1'b0);
    check("freeze_pre", S_OFF, 0, 0, 0);
    air_state = M_SET;
    tem_reg = 8'd40; set_tem = 8'd20;
    cycle(1'b0); cycle(1'b1);
    check("freeze_hold", S_OFF, 0, 0, 0);
    air_state = M_AUTO;
    cycle(1'b0);
    check("freeze_release_cool", S_COOL, 1, 0, 1);
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;

    // 9-bit comparison: 255 > 254 + 2 is false
    tem_reg = 8'd255; set_tem = 8'd254;
    cycle(1'b0);
    check("no_wrap_255", S_OFF, 0, 0, 0);
    cycle(1'b0);
    check("no_wrap_hold", S_OFF, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
